pipe_ctrl: RTL and testbench

- Central pipeline controller for the in-order CPU.
- Turns per-stage stall requests into the monotonic stall bus consumed by every inter-stage register, including dc and mem.
- Sequences exception/ERET redirection: one-cycle freeze, then one-cycle flush plus new-PC pulse.
- Provides a stall watchdog and a flush event counter for debug and performance.

---
 rtl/pipe_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the in-order CPU.
//
// Turns per-stage stall requests into a monotonic stall bus, sequences
// exception/ERET redirection (one-cycle freeze, then a one-cycle flush with a
// new-PC pulse), and provides a sticky stall watchdog and a saturating
// redirect counter.
//
// Ports:
//   clk            in   system clock, rising edge
//   resetn         in   asynchronous active-low reset
//   stallreq       in   [STALL_W]  stage s freezes itself and all upstream stages
//   except_req     in   exception committed in mem (single-cycle pulse)
//   except_target  in   [PC_W]     exception handler address
//   eret_req       in   ERET committed in mem (single-cycle pulse)
//   epc            in   [PC_W]     ERET return address
//   stall          out  [STALL_W]  stall bus, contiguous ones from bit 0
//   flush          out  clear all pipeline registers (registered)
//   new_pc         out  [PC_W]     redirect address (registered, held)
//   new_pc_valid   out  fetch loads new_pc (registered pulse with flush)
//   wdog_timeout   out  sticky watchdog flag
//   flush_cnt      out  [CNT_W]    saturating count of redirects taken
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal operation; stall follows stallreq, redirect freezes all
// ST_FLUSH | one-cycle flush; stall released, new requests ignored

module pipe_ctrl #(
   parameter int STALL_W  = 8,
   parameter int PC_W     = 32,
   parameter int WDOG_MAX = 1023,
   parameter int CNT_W    = 16
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [STALL_W-1:0] stallreq,
   input  logic               except_req,
   input  logic [PC_W-1:0]    except_target,
   input  logic               eret_req,
   input  logic [PC_W-1:0]    epc,
   output logic [STALL_W-1:0] stall,
   output logic               flush,
   output logic [PC_W-1:0]    new_pc,
   output logic               new_pc_valid,
   output logic               wdog_timeout,
   output logic [CNT_W-1:0]   flush_cnt
);

   localparam int WDOG_W = $clog2(WDOG_MAX + 1);
   // The flag trips on the edge where the count would reach WDOG_MAX.
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                flush_q, flush_d;
   logic                new_pc_valid_q, new_pc_valid_d;
   logic [PC_W-1:0]     new_pc_q, new_pc_d;
   logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
   logic                wdog_timeout_q, wdog_timeout_d;
   logic [WDOG_W-1:0]   wdog_cnt_q, wdog_cnt_d;
   logic [STALL_W-1:0]  stall_therm;
   logic [STALL_W-1:0]  stall_c;
   logic                acc;

   // Thermometer: stall[i] is set when any request at index >= i is set.
   always_comb begin
      acc         = 1'b0;
      stall_therm = '0;
      for (int i = STALL_W - 1; i >= 0; i--) begin
         acc            = acc | stallreq[i];
         stall_therm[i] = acc;
      end
   end

   always_comb begin
      state_d        = state_q;
      flush_d        = 1'b0;
      new_pc_valid_d = 1'b0;
      new_pc_d       = new_pc_q;
      flush_cnt_d    = flush_cnt_q;
      stall_c        = '0;

      case (state_q)
         ST_RUN: begin
            if (except_req || eret_req) begin
               stall_c        = '1;
               state_d        = ST_FLUSH;
               flush_d        = 1'b1;
               new_pc_valid_d = 1'b1;
               new_pc_d       = except_req ? except_target : epc;
               if (flush_cnt_q != '1) begin
                  flush_cnt_d = flush_cnt_q + CNT_W'(1);
               end
            end else begin
               stall_c = stall_therm;
            end
         end
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      // The stall bus is combinational; keep it quiet while reset is held.
      if (!resetn) begin
         stall_c = '0;
      end

      wdog_timeout_d = wdog_timeout_q;
      wdog_cnt_d     = '0;
      if (stall_c != '0) begin
         if (wdog_cnt_q == WDOG_LAST) begin
            wdog_timeout_d = 1'b1;
            wdog_cnt_d     = '0;
         end else begin
            wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= ST_RUN;
         flush_q        <= 1'b0;
         new_pc_valid_q <= 1'b0;
         new_pc_q       <= '0;
         flush_cnt_q    <= '0;
         wdog_timeout_q <= 1'b0;
         wdog_cnt_q     <= '0;
      end else begin
         state_q        <= state_d;
         flush_q        <= flush_d;
         new_pc_valid_q <= new_pc_valid_d;
         new_pc_q       <= new_pc_d;
         flush_cnt_q    <= flush_cnt_d;
         wdog_timeout_q <= wdog_timeout_d;
         wdog_cnt_q     <= wdog_cnt_d;
      end
   end

   assign stall        = stall_c;
   assign flush        = flush_q;
   assign new_pc       = new_pc_q;
   assign new_pc_valid = new_pc_valid_q;
   assign wdog_timeout = wdog_timeout_q;
   assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl (WDOG_MAX overridden to 15).

module tb_pipe_ctrl;

   logic        clk;
   logic        resetn;
   logic [7:0]  stallreq;
   logic        except_req;
   logic [31:0] except_target;
   logic        eret_req;
   logic [31:0] epc;
   logic [7:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        new_pc_valid;
   logic        wdog_timeout;
   logic [15:0] flush_cnt;

   pipe_ctrl #(
      .STALL_W  (8),
      .PC_W     (32),
      .WDOG_MAX (15),
      .CNT_W    (16)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .stallreq      (stallreq),
      .except_req    (except_req),
      .except_target (except_target),
      .eret_req      (eret_req),
      .epc           (epc),
      .stall         (stall),
      .flush         (flush),
      .new_pc        (new_pc),
      .new_pc_valid  (new_pc_valid),
      .wdog_timeout  (wdog_timeout),
      .flush_cnt     (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  sr;
      logic        exc;
      logic        eret;
      logic [31:0] tgt;
      logic [31:0] pc_in;
      logic [7:0]  e_stall;
      logic        e_flush;
      logic        e_npv;
      logic [31:0] e_pc;
      logic [15:0] e_cnt;
      logic        e_wd;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] sr, input logic exc, input logic eret,
                      input logic [31:0] tgt, input logic [31:0] pc_in,
                      input logic [7:0] e_stall, input logic e_flush,
                      input logic [31:0] e_pc, input logic [15:0] e_cnt);
      vec_t v;
      v.sr = sr; v.exc = exc; v.eret = eret; v.tgt = tgt; v.pc_in = pc_in;
      v.e_stall = e_stall; v.e_flush = e_flush; v.e_npv = e_flush;
      v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_wd = 1'b0;
      vecs.push_back(v);
   endtask

   task automatic idle_inputs();
      stallreq = 8'h00; except_req = 1'b0; eret_req = 1'b0;
      except_target = 32'h0; epc = 32'h0;
   endtask

   initial begin
      vec_t v;
      vec_t e;
      localparam logic [31:0] EXC = 32'hBFC0_0380;
      localparam logic [31:0] RET = 32'h8000_1000;

      //   sr     exc   eret  tgt            epc            stall  flush e_pc  cnt
      add(8'h00, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00, 1'b0, 32'h0, 16'd0);
      add(8'h08, 1'b0, 1'b0, 32'h0,         32'h0,         8'h0F, 1'b0, 32'h0, 16'd0);
      add(8'h24, 1'b0, 1'b0, 32'h0,         32'h0,         8'h3F, 1'b0, 32'h0, 16'd0);
      add(8'h80, 1'b0, 1'b0, 32'h0,         32'h0,         8'hFF, 1'b0, 32'h0, 16'd0);
      add(8'h00, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00, 1'b0, 32'h0, 16'd0);
      add(8'h01, 1'b0, 1'b0, 32'h0,         32'h0,         8'h01, 1'b0, 32'h0, 16'd0);
      // exception with stallreq=03: freeze, flush, release
      add(8'h03, 1'b1, 1'b0, EXC,           32'h0,         8'hFF, 1'b0, 32'h0, 16'd0);
      add(8'h03, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00, 1'b1, EXC,   16'd1);
      add(8'h03, 1'b0, 1'b0, 32'h0,         32'h0,         8'h03, 1'b0, EXC,   16'd1);
      // simultaneous requests, then a repeated exception during FLUSH
      add(8'h00, 1'b1, 1'b1, EXC,           RET,           8'hFF, 1'b0, EXC,   16'd1);
      add(8'h00, 1'b1, 1'b0, 32'h1234_5678, 32'h0,         8'h00, 1'b1, EXC,   16'd2);
      add(8'h00, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00, 1'b0, EXC,   16'd2);
      // ERET, then a second ERET two cycles later
      add(8'h00, 1'b0, 1'b1, 32'h0,         RET,           8'hFF, 1'b0, EXC,   16'd2);
      add(8'h00, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00, 1'b1, RET,   16'd3);
      add(8'h00, 1'b0, 1'b1, 32'h0,         32'h8000_2000, 8'hFF, 1'b0, RET,   16'd3);
      add(8'h00, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00, 1'b1, 32'h8000_2000, 16'd4);
      add(8'h00, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00, 1'b0, 32'h8000_2000, 16'd4);

      // Reset held from time 0, checked mid-cycle with a stall request pending.
      idle_inputs();
      stallreq = 8'h80;
      resetn   = 1'b0;
      #3;
      check("reset_stall", 32'(stall), 32'h00);
      check("reset_flush", 32'(flush), 32'h0);
      check("reset_npv", 32'(new_pc_valid), 32'h0);
      check("reset_pc", new_pc, 32'h0);
      check("reset_cnt", 32'(flush_cnt), 32'h0);
      check("reset_wd", 32'(wdog_timeout), 32'h0);
      stallreq = 8'h00;
      @(negedge clk);
      resetn = 1'b1;

      // Table-driven cycle-by-cycle sequence through the scoreboard.
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         v = vecs[i];
         stallreq = v.sr; except_req = v.exc; eret_req = v.eret;
         except_target = v.tgt; epc = v.pc_in;
         sb.push_back(v);
         @(negedge clk);
         e = sb.pop_front();
         check($sformatf("row%0d_stall", i), 32'(stall), 32'(e.e_stall));
         check($sformatf("row%0d_flush", i), 32'(flush), 32'(e.e_flush));
         check($sformatf("row%0d_npv", i), 32'(new_pc_valid), 32'(e.e_npv));
         check($sformatf("row%0d_pc", i), new_pc, e.e_pc);
         check($sformatf("row%0d_cnt", i), 32'(flush_cnt), 32'(e.e_cnt));
         check($sformatf("row%0d_wd", i), 32'(wdog_timeout), 32'(e.e_wd));
      end
      check("sb_empty", 32'(sb.size()), 32'd0);

      // Reset asserted in the middle of a flush cycle.
      @(posedge clk);
      #1;
      stallreq = 8'h80; except_req = 1'b1; except_target = 32'hBFC0_0380;
      @(posedge clk);
      #1;
      except_req = 1'b0;
      check("midflush_flush_hi", 32'(flush), 32'h1);
      #2;
      resetn = 1'b0;
      #1;
      check("midflush_flush", 32'(flush), 32'h0);
      check("midflush_npv", 32'(new_pc_valid), 32'h0);
      check("midflush_pc", new_pc, 32'h0);
      check("midflush_cnt", 32'(flush_cnt), 32'h0);
      check("midflush_stall", 32'(stall), 32'h00);
      idle_inputs();
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("post_reset_stall", 32'(stall), 32'h00);

      // Watchdog: 14 stalled cycles plus a free cycle must not trip.
      for (int c = 0; c < 14; c++) begin
         @(posedge clk); #1; stallreq = 8'h01;
      end
      @(posedge clk); #1; stallreq = 8'h00;
      @(negedge clk);
      check("wd_14_no_trip", 32'(wdog_timeout), 32'h0);

      // 15 stalled cycles trip it in cycle 16.
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1; stallreq = 8'h01;
      end
      @(negedge clk);
      check("wd_cycle15", 32'(wdog_timeout), 32'h0);
      @(posedge clk); #1; stallreq = 8'h00;
      @(negedge clk);
      check("wd_cycle16", 32'(wdog_timeout), 32'h1);
      check("wd_no_effect_stall", 32'(stall), 32'h00);
      for (int c = 0; c < 5; c++) @(posedge clk);
      @(negedge clk);
      check("wd_sticky", 32'(wdog_timeout), 32'h1);
      resetn = 1'b0;
      #1;
      check("wd_reset", 32'(wdog_timeout), 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
